ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the 5-stage MIPS pipeline. It consumes the ID/EX pipeline register outputs and applies operand forwarding. It computes the ALU result, zero flag, store data and destination register for the EX/MEM register. It also contains an iterative 32-cycle multiply/divide unit with HI/LO registers, and raises `stall` toward the hazard unit when an instruction needs HI/LO while that unit is busy.

## Interface
Parameters:
- `MD_CYCLES`, default 32: iterations per multiply/divide. Fixed at 32 for a 32-bit datapath.

Ports:
- `clk`  in  1  pipeline clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `validIN`  in  1  EX holds a real instruction. 0 marks a bubble, which has no side effects.
- `ALUSrcIN`, `ShiftIN`, `RegDstIN`  in  1 each  control bits from ID/EX.
- `ALUOpIN`  in  2  00 add, 01 sub, 10 R-type (decode by funct), 11 I-type (decode by opcode).
- `readData1IN`, `readData2IN`, `signExtIN`  in  32  operands; funct is `signExtIN[5:0]`.
- `ins20_16IN`, `ins15_11IN`, `ins10_6IN`  in  5  rt, rd, shamt.
- `ins31_26IN`  in  6  opcode.
- `fwdA`, `fwdB`  in  2  00 register value, 01 `memWbResult`, 10 `exMemResult`; 11 is treated as 00.
- `exMemResult`, `memWbResult`  in  32  forwarded values.
- `aluResult`  out  32  combinational result.
- `zero`  out  1  `aluResult == 0`.
- `storeData`  out  32  forwarded B operand, before the ALUSrc mux.
- `writeReg`  out  5  rd if `RegDstIN`, else rt.
- `stall`  out  1  freeze PC, IF/ID and ID/EX, and insert a bubble into EX/MEM.
- `busy`  out  1  multiply/divide sequencer running.

## Operation
- **Operand selection**
  - A is the forwarded rs; it is replaced by zero-extended `ins10_6IN` when `ShiftIN` is set (sll, srl, sra).
  - B is `signExtIN` when `ALUSrcIN` is set, else the forwarded rt.
  - andi, ori and xori use zero-extended `signExtIN[15:0]`.
- **R-type funct codes**
  - 00 sll, 02 srl, 03 sra, 04 sllv, 06 srlv, 07 srav (shift amount is A[4:0]).
  - 20/21 add, 22/23 sub, 24 and, 25 or, 26 xor, 27 nor, 2A slt, 2B sltu.
  - No overflow traps: add behaves as addu.
- **I-type opcodes**
  - 08/09 add, 0A slti, 0B sltiu, 0C andi, 0D ori, 0E xori, 0F lui (B<<16).
- **HI/LO funct codes**
  - 18 mult, 19 multu, 1A div, 1B divu, 10 mfhi, 11 mthi, 12 mflo, 13 mtlo.
  - mfhi and mflo drive HI or LO onto `aluResult`.
  - Any unlisted code yields `aluResult` = 0.
- **Sequencer states**
  - IDLE→RUN on a valid muldiv op while not stalled. Operands are latched as magnitudes, with sign flags for the signed ops. Count is cleared to 0.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. At count 31, sign-corrected HI/LO are written and the state returns to IDLE.
- **Results**
  - Multiply: {HI,LO} = 64-bit product.
  - Divide: LO = quotient truncated toward zero; HI = remainder, carrying the sign of the dividend.
  - Divide by zero: LO = FFFFFFFF, HI = dividend, after the same 32 cycles.
- **Stall rule**: `stall = validIN & busy & (op is mult/div/mfhi/mflo/mthi/mtlo)`.
  - Every other instruction flows through while the sequencer is busy.
  - mthi and mtlo write at the clock edge when valid and not stalled.

## Timing
- Reset values: state IDLE, count 0, HI = LO = 0, `busy` = 0, `stall` = 0.
- Reset mid-operation aborts the sequencer: HI/LO are cleared and no write occurs.
- ALU path is combinational, with 0 cycles of latency within EX.
- Muldiv in EX during cycle T:
  - `busy` is high during cycles T+1..T+32.
  - HI/LO are updated at the end of T+32.
  - mfhi in cycle T+33 returns the new value.
- A dependent mfhi/mflo reaching EX during cycles T+1..T+32 holds `stall` high until `busy` falls. It completes in cycle T+33.
- A back-to-back muldiv waits the same way. Its launch coincides with the first cycle after `busy` falls.
- `validIN` = 0 never launches the sequencer and never asserts `stall`.

## Structure
- Shared package `mips_pkg`:
  - ALUOp encodings
  - funct and opcode constants
  - forwarding-select encodings
  - sequencer state enum
- Sub-module `muldiv_seq`: sequencer FSM, counter, HI/LO registers, sign handling.
- `ex_stage` contains the forwarding muxes, ALU decode, stall logic and one instance of `muldiv_seq`.

## Test plan
- add with `fwdA`=10, `exMemResult`=5, rt=3 → `aluResult`=8, `zero`=0. Then sub 3−3 → `zero`=1.
- sra with shamt=4, rt=80000000 → F8000000; sltu FFFFFFFF<1 → 0; lui 1234 → 12340000.
- mult −3×7 then mflo one cycle later:
  - `stall` high for 32 cycles;
  - then HI=FFFFFFFF, LO=FFFFFFEB.
- div 7÷−2 → LO=FFFFFFFD, HI=1. divu 10÷0 → LO=FFFFFFFF, HI=0000000A.
- add issued during a busy multiply → no stall, correct result. A second mult while busy → stall until `busy` falls.
- `reset` asserted at RUN count 15 → `busy`=0 and HI=LO=0 next cycle. A later mfhi returns 0 with no stall.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the MIPS execute stage
package mips_pkg;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_ITYPE = 2'b11;

   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_MEMWB = 2'b01;
   localparam logic [1:0] FWD_EXMEM = 2'b10;

   localparam logic [5:0] F_SLL   = 6'h00;
   localparam logic [5:0] F_SRL   = 6'h02;
   localparam logic [5:0] F_SRA   = 6'h03;
   localparam logic [5:0] F_SLLV  = 6'h04;
   localparam logic [5:0] F_SRLV  = 6'h06;
   localparam logic [5:0] F_SRAV  = 6'h07;
   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;
   localparam logic [5:0] F_ADD   = 6'h20;
   localparam logic [5:0] F_ADDU  = 6'h21;
   localparam logic [5:0] F_SUB   = 6'h22;
   localparam logic [5:0] F_SUBU  = 6'h23;
   localparam logic [5:0] F_AND   = 6'h24;
   localparam logic [5:0] F_OR    = 6'h25;
   localparam logic [5:0] F_XOR   = 6'h26;
   localparam logic [5:0] F_NOR   = 6'h27;
   localparam logic [5:0] F_SLT   = 6'h2A;
   localparam logic [5:0] F_SLTU  = 6'h2B;

   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;

   typedef logic [0:0] md_state_t;
   localparam md_state_t MD_IDLE = 1'b0;
   localparam md_state_t MD_RUN  = 1'b1;

   function automatic logic is_muldiv_funct(input logic [5:0] fn);
      return fn inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
   endfunction

   function automatic logic is_hilo_funct(input logic [5:0] fn);
      return is_muldiv_funct(fn) || (fn inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO});
   endfunction

endpackage

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative multiply/divide sequencer with HI/LO registers
module muldiv_seq
   import mips_pkg::*;
#(
   parameter int MD_CYCLES = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        is_div,
   input  logic        is_signed,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        wr_hi,
   input  logic        wr_lo,
   input  logic [31:0] wr_data,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy
);

   localparam int CW = $clog2(MD_CYCLES);

   md_state_t      state;
   logic [CW-1:0]  count;
   logic [63:0]    acc;
   logic [31:0]    dsr;
   logic           div_q, neg_q, neg_r, div0;

   logic [31:0] a_mag, b_mag;
   logic [32:0] add_sum, rem_shift, diff;
   logic [63:0] acc_next, prod;
   logic [31:0] quot, rem;

   // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
   always_comb begin
      a_mag     = (is_signed && op_a[31]) ? (32'd0 - op_a) : op_a;
      b_mag     = (is_signed && op_b[31]) ? (32'd0 - op_b) : op_b;
      add_sum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? dsr : 32'd0)};
      rem_shift = {acc[63:32], acc[31]};
      diff      = rem_shift - {1'b0, dsr};
      if (div_q) begin
         acc_next = diff[32] ? {rem_shift[31:0], acc[30:0], 1'b0}
                             : {diff[31:0], acc[30:0], 1'b1};
      end else begin
         acc_next = {add_sum, acc[31:1]};
      end
      prod = neg_q ? (64'd0 - acc_next) : acc_next;
      quot = div0 ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - acc_next[31:0]) : acc_next[31:0]);
      rem  = neg_r ? (32'd0 - acc_next[63:32]) : acc_next[63:32];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= MD_IDLE;
         count <= '0;
         acc   <= '0;
         dsr   <= '0;
         div_q <= 1'b0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         div0  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         case (state)
            MD_IDLE: begin
               if (start) begin
                  state <= MD_RUN;
                  count <= '0;
                  acc   <= {32'd0, a_mag};
                  dsr   <= b_mag;
                  div_q <= is_div;
                  neg_q <= is_signed & (op_a[31] ^ op_b[31]);
                  neg_r <= is_signed & is_div & op_a[31];
                  div0  <= is_div & (op_b == 32'd0);
               end else begin
                  if (wr_hi) hi <= wr_data;
                  if (wr_lo) lo <= wr_data;
               end
            end
            default: begin
               acc   <= acc_next;
               count <= count + CW'(1);
               if (count == CW'(MD_CYCLES - 1)) begin
                  state <= MD_IDLE;
                  if (div_q) begin
                     hi <= rem;
                     lo <= quot;
                  end else begin
                     hi <= prod[63:32];
                     lo <= prod[31:0];
                  end
               end
            end
         endcase
      end
   end

   assign busy = (state == MD_RUN);

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: forwarding, ALU, HI/LO stall control
module ex_stage
   import mips_pkg::*;
#(
   parameter int MD_CYCLES = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        validIN,
   input  logic        ALUSrcIN,
   input  logic        ShiftIN,
   input  logic        RegDstIN,
   input  logic [1:0]  ALUOpIN,
   input  logic [31:0] readData1IN,
   input  logic [31:0] readData2IN,
   input  logic [31:0] signExtIN,
   input  logic [4:0]  ins20_16IN,
   input  logic [4:0]  ins15_11IN,
   input  logic [4:0]  ins10_6IN,
   input  logic [5:0]  ins31_26IN,
   input  logic [1:0]  fwdA,
   input  logic [1:0]  fwdB,
   input  logic [31:0] exMemResult,
   input  logic [31:0] memWbResult,
   output logic [31:0] aluResult,
   output logic        zero,
   output logic [31:0] storeData,
   output logic [4:0]  writeReg,
   output logic        stall,
   output logic        busy
);

   logic [31:0] fwd_a, fwd_b, op_a, op_b, zimm, hi, lo;
   logic [5:0]  funct;
   logic [4:0]  sh;
   logic        rtype, is_md, issue;

   always_comb begin
      case (fwdA)
         FWD_MEMWB: fwd_a = memWbResult;
         FWD_EXMEM: fwd_a = exMemResult;
         default:   fwd_a = readData1IN;
      endcase
      case (fwdB)
         FWD_MEMWB: fwd_b = memWbResult;
         FWD_EXMEM: fwd_b = exMemResult;
         default:   fwd_b = readData2IN;
      endcase
   end

   assign op_a  = ShiftIN ? {27'd0, ins10_6IN} : fwd_a;
   assign op_b  = ALUSrcIN ? signExtIN : fwd_b;
   assign zimm  = {16'd0, signExtIN[15:0]};
   assign funct = signExtIN[5:0];
   assign sh    = op_a[4:0];

   always_comb begin
      aluResult = '0;
      case (ALUOpIN)
         ALUOP_ADD: aluResult = op_a + op_b;
         ALUOP_SUB: aluResult = op_a - op_b;
         ALUOP_RTYPE: begin
            case (funct)
               F_SLL, F_SLLV:  aluResult = op_b << sh;
               F_SRL, F_SRLV:  aluResult = op_b >> sh;
               F_SRA, F_SRAV:  aluResult = $unsigned($signed(op_b) >>> sh);
               F_ADD, F_ADDU:  aluResult = op_a + op_b;
               F_SUB, F_SUBU:  aluResult = op_a - op_b;
               F_AND:          aluResult = op_a & op_b;
               F_OR:           aluResult = op_a | op_b;
               F_XOR:          aluResult = op_a ^ op_b;
               F_NOR:          aluResult = ~(op_a | op_b);
               F_SLT:          aluResult = {31'd0, $signed(op_a) < $signed(op_b)};
               F_SLTU:         aluResult = {31'd0, op_a < op_b};
               F_MFHI:         aluResult = hi;
               F_MFLO:         aluResult = lo;
               default:        aluResult = '0;
            endcase
         end
         default: begin
            case (ins31_26IN)
               OP_ADDI, OP_ADDIU: aluResult = op_a + op_b;
               OP_SLTI:           aluResult = {31'd0, $signed(op_a) < $signed(op_b)};
               OP_SLTIU:          aluResult = {31'd0, op_a < op_b};
               OP_ANDI:           aluResult = op_a & zimm;
               OP_ORI:            aluResult = op_a | zimm;
               OP_XORI:           aluResult = op_a ^ zimm;
               OP_LUI:            aluResult = op_b << 16;
               default:           aluResult = '0;
            endcase
         end
      endcase
   end

   assign zero      = (aluResult == 32'd0);
   assign storeData = fwd_b;
   assign writeReg  = RegDstIN ? ins15_11IN : ins20_16IN;

   // Only HI/LO consumers wait on the sequencer; everything else flows past it.
   assign rtype = (ALUOpIN == ALUOP_RTYPE);
   assign is_md = rtype & is_muldiv_funct(funct);
   assign stall = validIN & busy & rtype & is_hilo_funct(funct);
   assign issue = validIN & ~stall & rtype;

   muldiv_seq #(.MD_CYCLES(MD_CYCLES)) u_muldiv (
      .clk       (clk),
      .reset     (reset),
      .start     (issue & is_md),
      .is_div    (funct[1]),
      .is_signed (~funct[0]),
      .op_a      (fwd_a),
      .op_b      (fwd_b),
      .wr_hi     (issue & (funct == F_MTHI)),
      .wr_lo     (issue & (funct == F_MTLO)),
      .wr_data   (fwd_a),
      .hi        (hi),
      .lo        (lo),
      .busy      (busy)
   );

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - randomized self-checking bench for ex_stage
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        validIN, ALUSrcIN, ShiftIN, RegDstIN;
   logic [1:0]  ALUOpIN, fwdA, fwdB;
   logic [31:0] readData1IN, readData2IN, signExtIN, exMemResult, memWbResult;
   logic [4:0]  ins20_16IN, ins15_11IN, ins10_6IN;
   logic [5:0]  ins31_26IN;
   logic [31:0] aluResult, storeData;
   logic        zero, stall, busy;
   logic [4:0]  writeReg;

   int checks = 0;
   int errors = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   localparam logic [5:0] ALU_FN [0:18] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
      6'h10, 6'h12, 6'h3F};
   localparam logic [5:0] I_OPC [0:8] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
      6'h0E, 6'h0F, 6'h23};
   localparam logic [5:0] MD_FN [0:3] = '{6'h18, 6'h19, 6'h1A, 6'h1B};

   ex_stage #(.MD_CYCLES(32)) dut (
      .clk(clk), .reset(reset), .validIN(validIN), .ALUSrcIN(ALUSrcIN),
      .ShiftIN(ShiftIN), .RegDstIN(RegDstIN), .ALUOpIN(ALUOpIN),
      .readData1IN(readData1IN), .readData2IN(readData2IN), .signExtIN(signExtIN),
      .ins20_16IN(ins20_16IN), .ins15_11IN(ins15_11IN), .ins10_6IN(ins10_6IN),
      .ins31_26IN(ins31_26IN), .fwdA(fwdA), .fwdB(fwdB),
      .exMemResult(exMemResult), .memWbResult(memWbResult),
      .aluResult(aluResult), .zero(zero), .storeData(storeData),
      .writeReg(writeReg), .stall(stall), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] r,
                                        input logic [31:0] mw, input logic [31:0] em);
      if (s == 2'd1) return mw;
      if (s == 2'd2) return em;
      return r;
   endfunction

   // Reference ALU from the instruction semantics
   function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [5:0] fn,
                                           input logic [5:0] opc, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] imm);
      logic [31:0] zi;
      int unsigned n;
      zi = imm & 32'h0000_FFFF;
      n  = a % 32;
      if (op == 2'd0) return a + b;
      if (op == 2'd1) return a - b;
      if (op == 2'd2) begin
         case (fn)
            6'h00, 6'h04: return b * (32'd1 << n);
            6'h02, 6'h06: return b / (32'd1 << n);
            6'h03, 6'h07: return 32'(longint'($signed(b)) >>> n);
            6'h20, 6'h21: return a + b;
            6'h22, 6'h23: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h26: return a ^ b;
            6'h27: return ~(a | b);
            6'h2A: return (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
            6'h2B: return (a < b) ? 32'd1 : 32'd0;
            6'h10: return m_hi;
            6'h12: return m_lo;
            default: return 32'd0;
         endcase
      end
      case (opc)
         6'h08, 6'h09: return a + b;
         6'h0A: return (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
         6'h0B: return (a < b) ? 32'd1 : 32'd0;
         6'h0C: return a & zi;
         6'h0D: return a | zi;
         6'h0E: return a ^ zi;
         6'h0F: return b * 32'h0001_0000;
         default: return 32'd0;
      endcase
   endfunction

   task automatic ref_muldiv(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
      longint q, r, p;
      logic [63:0] pu;
      case (fn)
         6'h18: begin
            p = longint'($signed(a)) * longint'($signed(b));
            m_hi = p[63:32]; m_lo = p[31:0];
         end
         6'h19: begin
            pu = {32'd0, a} * {32'd0, b};
            m_hi = pu[63:32]; m_lo = pu[31:0];
         end
         6'h1A: begin
            if (b == 0) begin
               m_lo = 32'hFFFF_FFFF; m_hi = a;
            end else begin
               q = longint'($signed(a)) / longint'($signed(b));
               r = longint'($signed(a)) % longint'($signed(b));
               m_lo = q[31:0]; m_hi = r[31:0];
            end
         end
         default: begin
            if (b == 0) begin
               m_lo = 32'hFFFF_FFFF; m_hi = a;
            end else begin
               m_lo = a / b; m_hi = a % b;
            end
         end
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic src, input logic sh,
                        input logic rd, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] se, input logic [5:0] opc,
                        input logic [1:0] fa, input logic [1:0] fb,
                        input logic [31:0] em, input logic [31:0] mw, input logic [4:0] shamt);
      validIN = v; ALUOpIN = op; ALUSrcIN = src; ShiftIN = sh; RegDstIN = rd;
      readData1IN = r1; readData2IN = r2; signExtIN = se; ins31_26IN = opc;
      fwdA = fa; fwdB = fb; exMemResult = em; memWbResult = mw; ins10_6IN = shamt;
      ins20_16IN = 5'd7; ins15_11IN = 5'd9;
   endtask

   task automatic set_r(input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt);
      drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b1, rs, rt, {26'd0, fn}, 6'd0, 2'd0, 2'd0, 32'd0, 32'd0, 5'd0);
   endtask

   task automatic set_bubble(input logic [5:0] fn);
      drive(1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4, {26'd0, fn}, 6'd0, 2'd0, 2'd0, 32'd0, 32'd0, 5'd0);
   endtask

   task automatic wait_stall(output int n);
      n = 0;
      while (stall === 1'b1 && n < 100) begin
         n++;
         tick();
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      set_bubble(6'h00);
      repeat (3) tick();
      reset = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b expected 0", stall); end
      set_r(6'h10, 32'd0, 32'd0); #1;
      check32("reset_hi", aluResult, 32'd0);
      set_r(6'h12, 32'd0, 32'd0); #1;
      check32("reset_lo", aluResult, 32'd0);
      tick();
   endtask

   task automatic test_directed_alu();
      drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 32'd99, 32'd3, 32'd0, 6'd0, 2'b10, 2'b00, 32'd5, 32'd77, 5'd0); #1;
      check32("add_fwd", aluResult, 32'd8);
      checks++; if (zero !== 1'b0) begin errors++; $display("FAIL add_zero got %b expected 0", zero); end
      drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 32'd3, 32'd3, 32'd0, 6'd0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd0); #1;
      checks++; if (zero !== 1'b1) begin errors++; $display("FAIL sub_zero got %b expected 1", zero); end
      drive(1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 32'd0, 32'h8000_0000, 32'h03, 6'd0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd4); #1;
      check32("sra", aluResult, 32'hF800_0000);
      set_r(6'h2B, 32'hFFFF_FFFF, 32'd1); #1;
      check32("sltu", aluResult, 32'd0);
      drive(1'b1, 2'b11, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'h1234, 6'h0F, 2'b00, 2'b00, 32'd0, 32'd0, 5'd0); #1;
      check32("lui", aluResult, 32'h1234_0000);
      check32("lui_wreg", {27'd0, writeReg}, 32'd7);
      tick();
   endtask

   task automatic test_random_alu();
      logic [1:0]  op, fa, fb;
      logic        src, sh, rd;
      logic [5:0]  fn, opc;
      logic [31:0] r1, r2, se, em, mw, a, b, exp;
      logic [4:0]  shamt;
      for (int i = 0; i < 150; i++) begin
         op = 2'($urandom_range(0, 3));
         fa = 2'($urandom_range(0, 3)); fb = 2'($urandom_range(0, 3));
         src = 1'($urandom); rd = 1'($urandom);
         fn = ALU_FN[$urandom_range(0, 18)];
         opc = I_OPC[$urandom_range(0, 8)];
         r1 = $urandom; r2 = $urandom; em = $urandom; mw = $urandom;
         se = {$urandom} & 32'hFFFF_FFC0 | {26'd0, fn};
         shamt = 5'($urandom);
         if (op == 2'd3) src = 1'b1;
         sh = (op == 2'd2) ? (fn inside {6'h00, 6'h02, 6'h03}) : ((op == 2'd3) ? 1'b0 : 1'($urandom));
         if ($urandom_range(0, 7) == 0) begin r1 = r2; fa = 2'd0; fb = 2'd0; src = 1'b0; sh = 1'b0; end
         drive(1'b1, op, src, sh, rd, r1, r2, se, opc, fa, fb, em, mw, shamt); #1;
         a = sh ? {27'd0, shamt} : pick(fa, r1, mw, em);
         b = src ? se : pick(fb, r2, mw, em);
         exp = ref_alu(op, fn, opc, a, b, se);
         check32("rand_alu", aluResult, exp);
         checks++; if (zero !== (exp == 32'd0)) begin errors++; $display("FAIL rand_zero got %b expected %b", zero, exp == 32'd0); end
         check32("rand_store", storeData, pick(fb, r2, mw, em));
         check32("rand_wreg", {27'd0, writeReg}, rd ? 32'd9 : 32'd7);
         checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rand_stall got %b expected 0", stall); end
         tick();
      end
   endtask

   task automatic test_mult_stall();
      int n;
      set_r(6'h18, 32'hFFFF_FFFD, 32'd7); #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mult_issue_stall got %b expected 0", stall); end
      ref_muldiv(6'h18, 32'hFFFF_FFFD, 32'd7);
      tick();
      set_r(6'h12, 32'd0, 32'd0); #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy got %b expected 1", busy); end
      wait_stall(n);
      check32("mult_stall_len", n, 32'd32);
      check32("mult_lo", aluResult, 32'hFFFF_FFEB);
      tick();
      set_r(6'h10, 32'd0, 32'd0); #1;
      check32("mult_hi", aluResult, 32'hFFFF_FFFF);
      tick();
   endtask

   task automatic test_div();
      int n;
      logic [31:0] dv [0:1];
      logic [31:0] ds [0:1];
      logic [5:0]  fn [0:1];
      logic [31:0] elo [0:1];
      logic [31:0] ehi [0:1];
      dv = '{32'd7, 32'd10}; ds = '{32'hFFFF_FFFE, 32'd0}; fn = '{6'h1A, 6'h1B};
      elo = '{32'hFFFF_FFFD, 32'hFFFF_FFFF}; ehi = '{32'd1, 32'h0000_000A};
      for (int i = 0; i < 2; i++) begin
         set_r(fn[i], dv[i], ds[i]);
         ref_muldiv(fn[i], dv[i], ds[i]);
         tick();
         set_r(6'h12, 32'd0, 32'd0); #1;
         wait_stall(n);
         check32("div_stall_len", n, 32'd32);
         check32("div_lo", aluResult, elo[i]);
         tick();
         set_r(6'h10, 32'd0, 32'd0); #1;
         check32("div_hi", aluResult, ehi[i]);
         tick();
      end
   endtask

   task automatic test_back_to_back();
      int n;
      set_r(6'h19, 32'd123456, 32'd654321);
      tick();
      drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 32'd100, 32'd23, 32'd0, 6'd0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd0); #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL overlap_add_stall got %b expected 0", stall); end
      check32("overlap_add", aluResult, 32'd123);
      tick();
      set_r(6'h18, 32'h8000_0001, 32'hFFFF_FF00); #1;
      wait_stall(n);
      check32("mult2_stall_len", n, 32'd31);
      ref_muldiv(6'h18, 32'h8000_0001, 32'hFFFF_FF00);
      tick();
      set_r(6'h12, 32'd0, 32'd0); #1;
      wait_stall(n);
      check32("mult2_wait", n, 32'd32);
      check32("mult2_lo", aluResult, m_lo);
      tick();
      set_r(6'h10, 32'd0, 32'd0); #1;
      check32("mult2_hi", aluResult, m_hi);
      tick();
   endtask

   task automatic test_bubble();
      set_bubble(6'h18);
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bubble_launch got %b expected 0", busy); end
      set_r(6'h19, 32'hFFFF_FFFF, 32'd2);
      ref_muldiv(6'h19, 32'hFFFF_FFFF, 32'd2);
      tick();
      set_bubble(6'h10); #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL bubble_stall got %b expected 0", stall); end
      repeat (35) tick();
      set_r(6'h10, 32'd0, 32'd0); #1;
      check32("bubble_hi", aluResult, m_hi);
      tick();
   endtask

   task automatic test_random_muldiv();
      int n;
      logic [5:0]  fn;
      logic [31:0] a, b;
      for (int i = 0; i < 10; i++) begin
         fn = MD_FN[$urandom_range(0, 3)];
         a = $urandom; b = $urandom;
         if ($urandom_range(0, 3) == 0) b = 32'd0;
         if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 28);
         set_r(fn, a, b);
         ref_muldiv(fn, a, b);
         tick();
         set_r(6'h10, 32'd0, 32'd0); #1;
         wait_stall(n);
         check32("rmd_stall_len", n, 32'd32);
         check32("rmd_hi", aluResult, m_hi);
         tick();
         set_r(6'h12, 32'd0, 32'd0); #1;
         check32("rmd_lo", aluResult, m_lo);
         tick();
         a = $urandom; b = $urandom;
         drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, {26'd0, 6'h11}, 6'd0, 2'b10, 2'b00, a, 32'd0, 5'd0);
         tick();
         drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, {26'd0, 6'h13}, 6'd0, 2'b01, 2'b00, 32'd0, b, 5'd0);
         m_hi = a; m_lo = b;
         tick();
         set_r(6'h10, 32'd0, 32'd0); #1;
         check32("mthi", aluResult, m_hi);
         set_r(6'h12, 32'd0, 32'd0); #1;
         check32("mtlo", aluResult, m_lo);
         tick();
      end
   endtask

   task automatic test_reset_mid();
      set_r(6'h11, 32'hDEAD_0001, 32'd0); tick();
      set_r(6'h13, 32'hBEEF_0002, 32'd0); tick();
      set_r(6'h18, 32'd5, 32'd6);
      tick();
      set_bubble(6'h00);
      repeat (15) tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b expected 1", busy); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_hi = 32'd0; m_lo = 32'd0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b expected 0", busy); end
      set_r(6'h10, 32'd0, 32'd0); #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_reset_stall got %b expected 0", stall); end
      check32("mid_reset_hi", aluResult, 32'd0);
      set_r(6'h12, 32'd0, 32'd0); #1;
      check32("mid_reset_lo", aluResult, 32'd0);
      tick();
   endtask

   initial begin
      reset = 1'b1;
      set_bubble(6'h00);
      test_reset();
      test_directed_alu();
      test_random_alu();
      test_mult_stall();
      test_div();
      test_back_to_back();
      test_bubble();
      test_random_muldiv();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
